// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: forwarding selects, load-use/branch/multiply-divide stalls,
// and the multiply/divide occupancy FSM that sequences the shared HI/LO unit.
module hazard_control_unit #(
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter int unsigned MUL_CYCLES    = 4,
  parameter int unsigned DIV_CYCLES    = 32
) (
  input  logic                     i_CLK,
  input  logic                     i_RST_n,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsE,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic                     i_RegWriteE,
  input  logic                     i_RegWriteM,
  input  logic                     i_RegWriteW,
  input  logic                     i_MemtoRegE,
  input  logic                     i_MemtoRegM,
  input  logic                     i_BranchD,
  input  logic                     i_MDStartD,
  input  logic                     i_MDOpD,
  input  logic                     i_HiLoReadD,
  output logic [1:0]               o_ForwardAE,
  output logic [1:0]               o_ForwardBE,
  output logic                     o_ForwardAD,
  output logic                     o_ForwardBD,
  output logic                     o_StallF,
  output logic                     o_StallD,
  output logic                     o_FlushE,
  output logic                     o_MDStartE,
  output logic                     o_MDBusy,
  output logic                     o_MDDone
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            start_e_q, start_e_d;

  logic m_hit_a, w_hit_a, m_hit_b, w_hit_b;
  logic lu_stall, br_stall, md_stall, stall_any, md_accept;
  logic rs_d_nz, rt_d_nz;

  // Forwarding: register 0 is hard-wired and never forwarded.
  always_comb begin
    m_hit_a = i_RegWriteM && (i_WriteRegM != '0) && (i_WriteRegM == i_RsE);
    w_hit_a = i_RegWriteW && (i_WriteRegW != '0) && (i_WriteRegW == i_RsE);
    m_hit_b = i_RegWriteM && (i_WriteRegM != '0) && (i_WriteRegM == i_RtE);
    w_hit_b = i_RegWriteW && (i_WriteRegW != '0) && (i_WriteRegW == i_RtE);

    o_ForwardAE = m_hit_a ? 2'b10 : (w_hit_a ? 2'b01 : 2'b00);
    o_ForwardBE = m_hit_b ? 2'b10 : (w_hit_b ? 2'b01 : 2'b00);

    rs_d_nz     = (i_RsD != '0);
    rt_d_nz     = (i_RtD != '0);
    o_ForwardAD = rs_d_nz && (i_RsD == i_WriteRegM) && i_RegWriteM;
    o_ForwardBD = rt_d_nz && (i_RtD == i_WriteRegM) && i_RegWriteM;
  end

  always_comb begin
    lu_stall = i_MemtoRegE && (i_RtE != '0) && ((i_RtE == i_RsD) || (i_RtE == i_RtD));
    br_stall = i_BranchD &&
               ((i_RegWriteE && (i_WriteRegE != '0) &&
                 ((i_WriteRegE == i_RsD) || (i_WriteRegE == i_RtD))) ||
                (i_MemtoRegM && (i_WriteRegM != '0) &&
                 ((i_WriteRegM == i_RsD) || (i_WriteRegM == i_RtD))));
    // The MD term is masked in reset so a stale BUSY state cannot freeze the front end.
    md_stall  = i_RST_n && o_MDBusy && (i_MDStartD || i_HiLoReadD);
    stall_any = lu_stall || br_stall || md_stall;

    o_StallF = stall_any;
    o_StallD = stall_any;
    o_FlushE = stall_any;
  end

  assign o_MDBusy   = (state_q == StBusy);
  assign o_MDDone   = (state_q == StDone);
  assign o_MDStartE = start_e_q;

  // A start is taken from IDLE or DONE only, and only when decode actually advances.
  assign md_accept = (state_q != StBusy) && i_MDStartD && !stall_any;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_e_d = 1'b0;
    case (state_q)
      StIdle: state_d = StIdle;
      StBusy: begin
        if (cnt_q == '0) state_d = StDone;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (md_accept) begin
      state_d   = StBusy;
      cnt_d     = i_MDOpD ? DivLoad : MulLoad;
      start_e_d = 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      start_e_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_e_q <= start_e_d;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus randomized
// traffic checked against a cycle-count reference model.
module tb_hazard_control_unit;

  localparam int unsigned AW  = 5;
  localparam int unsigned MUL = 4;
  localparam int unsigned DIV = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic          rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, md_start_d, md_op_d, hilo_d;
  logic [1:0]    fwd_ae, fwd_be;
  logic          fwd_ad, fwd_bd, stall_f, stall_d, flush_e, md_start_e, md_busy, md_done;

  hazard_control_unit #(
    .RF_ADDR_WIDTH(AW),
    .MUL_CYCLES   (MUL),
    .DIV_CYCLES   (DIV)
  ) dut (
    .i_CLK      (clk),
    .i_RST_n    (rst_n),
    .i_RsD      (rs_d),
    .i_RtD      (rt_d),
    .i_RsE      (rs_e),
    .i_RtE      (rt_e),
    .i_WriteRegE(wr_e),
    .i_WriteRegM(wr_m),
    .i_WriteRegW(wr_w),
    .i_RegWriteE(rw_e),
    .i_RegWriteM(rw_m),
    .i_RegWriteW(rw_w),
    .i_MemtoRegE(m2r_e),
    .i_MemtoRegM(m2r_m),
    .i_BranchD  (br_d),
    .i_MDStartD (md_start_d),
    .i_MDOpD    (md_op_d),
    .i_HiLoReadD(hilo_d),
    .o_ForwardAE(fwd_ae),
    .o_ForwardBE(fwd_be),
    .o_ForwardAD(fwd_ad),
    .o_ForwardBD(fwd_bd),
    .o_StallF   (stall_f),
    .o_StallD   (stall_d),
    .o_FlushE   (flush_e),
    .o_MDStartE (md_start_e),
    .o_MDBusy   (md_busy),
    .o_MDDone   (md_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: number of BUSY cycles still owed, plus one-cycle pulse flags.
  int m_busy_left = 0;
  bit m_done      = 1'b0;
  bit m_start     = 1'b0;

  function automatic logic [1:0] exp_fwd_e(input logic [AW-1:0] src);
    if (rw_m && wr_m != 0 && wr_m == src) return 2'b10;
    if (rw_w && wr_w != 0 && wr_w == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_fwd_d(input logic [AW-1:0] src);
    return (src != 0) && (src == wr_m) && rw_m;
  endfunction

  function automatic logic exp_stall();
    logic lu, br, md;
    lu = m2r_e && rt_e != 0 && (rt_e == rs_d || rt_e == rt_d);
    br = br_d && ((rw_e && wr_e != 0 && (wr_e == rs_d || wr_e == rt_d)) ||
                  (m2r_m && wr_m != 0 && (wr_m == rs_d || wr_m == rt_d)));
    md = rst_n && (m_busy_left > 0) && (md_start_d || hilo_d);
    return lu || br || md;
  endfunction

  task automatic clear_inputs();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0; wr_e = '0; wr_m = '0; wr_w = '0;
    rw_e = 0; rw_m = 0; rw_w = 0; m2r_e = 0; m2r_m = 0; br_d = 0;
    md_start_d = 0; md_op_d = 0; hilo_d = 0;
  endtask

  // Advance one clock and the model with it; returns at the following negedge.
  task automatic tick();
    bit accept;
    @(posedge clk);
    accept = rst_n && (m_busy_left == 0) && md_start_d && !exp_stall();
    if (!rst_n) begin
      m_busy_left = 0; m_done = 0; m_start = 0;
    end else if (accept) begin
      m_busy_left = md_op_d ? DIV : MUL; m_start = 1; m_done = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--; m_start = 0; m_done = (m_busy_left == 0);
    end else begin
      m_start = 0; m_done = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    md_start_d = 1; hilo_d = 1; rw_m = 1; wr_m = 5'd8; rs_e = 5'd8;
    #1;
    n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", md_busy); end
    n_cmp++; if (md_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", md_done); end
    n_cmp++; if (md_start_e !== 1'b0) begin n_err++; $display("FAIL reset_starte: got %b want 0", md_start_e); end
    n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_f); end
    n_cmp++; if (fwd_ae !== 2'b10) begin n_err++; $display("FAIL reset_fwd_follows: got %b want 10", fwd_ae); end
    tick();
    clear_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forward_directed();
    clear_inputs();
    rw_m = 1; wr_m = 5'd8; rw_w = 1; wr_w = 5'd8; rs_e = 5'd8;
    #1;
    n_cmp++; if (fwd_ae !== 2'b10) begin n_err++; $display("FAIL fwd_m_prio: got %b want 10", fwd_ae); end
    rw_m = 0;
    #1;
    n_cmp++; if (fwd_ae !== 2'b01) begin n_err++; $display("FAIL fwd_w: got %b want 01", fwd_ae); end
    rw_m = 1; wr_m = '0; wr_w = '0; rs_e = '0;
    #1;
    n_cmp++; if (fwd_ae !== 2'b00) begin n_err++; $display("FAIL fwd_r0: got %b want 00", fwd_ae); end
    tick();
  endtask

  task automatic test_forward_random();
    for (int i = 0; i < 300; i++) begin
      rs_d = AW'($urandom_range(0, 3)); rt_d = AW'($urandom_range(0, 3));
      rs_e = AW'($urandom_range(0, 3)); rt_e = AW'($urandom_range(0, 3));
      wr_e = AW'($urandom_range(0, 3)); wr_m = AW'($urandom_range(0, 3));
      wr_w = AW'($urandom_range(0, 3));
      {rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, hilo_d} = 7'($urandom);
      md_start_d = 0;
      #1;
      n_cmp++; if (fwd_ae !== exp_fwd_e(rs_e)) begin n_err++; $display("FAIL rnd_fwd_ae: got %b want %b", fwd_ae, exp_fwd_e(rs_e)); end
      n_cmp++; if (fwd_be !== exp_fwd_e(rt_e)) begin n_err++; $display("FAIL rnd_fwd_be: got %b want %b", fwd_be, exp_fwd_e(rt_e)); end
      n_cmp++; if (fwd_ad !== exp_fwd_d(rs_d)) begin n_err++; $display("FAIL rnd_fwd_ad: got %b want %b", fwd_ad, exp_fwd_d(rs_d)); end
      n_cmp++; if (fwd_bd !== exp_fwd_d(rt_d)) begin n_err++; $display("FAIL rnd_fwd_bd: got %b want %b", fwd_bd, exp_fwd_d(rt_d)); end
      n_cmp++; if ({stall_f, stall_d, flush_e} !== {3{exp_stall()}}) begin
        n_err++; $display("FAIL rnd_stall: got %b%b%b want %b", stall_f, stall_d, flush_e, exp_stall());
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    m2r_e = 1; rt_e = 5'd5; rs_d = 5'd5;
    #1;
    n_cmp++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin n_err++; $display("FAIL load_use_on: got %b%b%b want 111", stall_f, stall_d, flush_e); end
    rt_e = '0; rs_d = '0;
    #1;
    n_cmp++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin n_err++; $display("FAIL load_use_r0: got %b%b%b want 000", stall_f, stall_d, flush_e); end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch();
    clear_inputs();
    br_d = 1; rw_e = 1; wr_e = 5'd3; rt_d = 5'd3;
    #1;
    n_cmp++; if (stall_f !== 1'b1) begin n_err++; $display("FAIL branch_stall_e: got %b want 1", stall_f); end
    tick();
    rw_e = 0; wr_e = '0; rw_m = 1; wr_m = 5'd3; m2r_m = 0;
    #1;
    n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL branch_nostall_m: got %b want 0", stall_f); end
    n_cmp++; if (fwd_bd !== 1'b1) begin n_err++; $display("FAIL branch_fwd_bd: got %b want 1", fwd_bd); end
    m2r_m = 1;
    #1;
    n_cmp++; if (stall_f !== 1'b1) begin n_err++; $display("FAIL branch_stall_load_m: got %b want 1", stall_f); end
    tick();
    clear_inputs();
  endtask

  task automatic test_md_latency(input bit op);
    int len, nbusy, first_busy, ndone, done_idx, nstart, start_idx;
    len = op ? DIV : MUL;
    nbusy = 0; first_busy = -1; ndone = 0; done_idx = -1; nstart = 0; start_idx = -1;
    clear_inputs();
    md_start_d = 1; md_op_d = op;
    tick();
    md_start_d = 0;
    for (int c = 1; c <= 60; c++) begin
      #1;
      if (md_busy === 1'b1) begin nbusy++; if (first_busy < 0) first_busy = c; end
      if (md_done === 1'b1) begin ndone++; done_idx = c; end
      if (md_start_e === 1'b1) begin nstart++; start_idx = c; end
      tick();
    end
    n_cmp++; if (nbusy != len) begin n_err++; $display("FAIL md_busy_len op%0d: got %0d want %0d", op, nbusy, len); end
    n_cmp++; if (first_busy != 1) begin n_err++; $display("FAIL md_busy_first op%0d: got %0d want 1", op, first_busy); end
    n_cmp++; if (ndone != 1 || done_idx != len + 1) begin
      n_err++; $display("FAIL md_done op%0d: got %0d pulses at %0d want 1 at %0d", op, ndone, done_idx, len + 1);
    end
    n_cmp++; if (nstart != 1 || start_idx != 1) begin
      n_err++; $display("FAIL md_starte op%0d: got %0d pulses at %0d want 1 at 1", op, nstart, start_idx);
    end
  endtask

  task automatic test_div_hilo();
    int nstart, ndone;
    clear_inputs();
    md_start_d = 1; md_op_d = 1;
    tick();
    md_op_d = 0; hilo_d = 1;  // second start (multiply) held while divide is busy
    for (int c = 1; c <= DIV; c++) begin
      #1;
      n_cmp++; if (stall_f !== 1'b1 || md_busy !== 1'b1) begin
        n_err++; $display("FAIL div_hold c%0d: stall %b busy %b want 1 1", c, stall_f, md_busy);
      end
      tick();
    end
    #1;
    n_cmp++; if (md_done !== 1'b1 || stall_f !== 1'b0) begin
      n_err++; $display("FAIL div_done_release: done %b stall %b want 1 0", md_done, stall_f);
    end
    tick();
    md_start_d = 0; hilo_d = 0;
    #1;
    n_cmp++; if (md_busy !== 1'b1 || md_start_e !== 1'b1) begin
      n_err++; $display("FAIL held_start_accept: busy %b starte %b want 1 1", md_busy, md_start_e);
    end
    tick();
    nstart = 0; ndone = 0;
    for (int c = 0; c < MUL + 3; c++) begin
      #1;
      if (md_start_e === 1'b1) nstart++;
      if (md_done === 1'b1) ndone++;
      tick();
    end
    n_cmp++; if (nstart != 0 || ndone != 1) begin
      n_err++; $display("FAIL held_start_once: extra starts %0d dones %0d want 0 1", nstart, ndone);
    end
  endtask

  task automatic test_reset_abort();
    int nbusy, ndone;
    clear_inputs();
    md_start_d = 1; md_op_d = 1;
    tick();
    md_start_d = 0;
    for (int c = 1; c < 10; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin
      n_err++; $display("FAIL abort_idle: busy %b done %b want 0 0", md_busy, md_done);
    end
    nbusy = 0; ndone = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (md_busy === 1'b1) nbusy++;
      if (md_done === 1'b1) ndone++;
      tick();
    end
    n_cmp++; if (nbusy != 0 || ndone != 0) begin
      n_err++; $display("FAIL abort_no_done: busy %0d done %0d want 0 0", nbusy, ndone);
    end
  endtask

  task automatic test_random_md();
    for (int i = 0; i < 800; i++) begin
      rs_d = AW'($urandom_range(0, 3)); rt_d = AW'($urandom_range(0, 3));
      rs_e = AW'($urandom_range(0, 3)); rt_e = AW'($urandom_range(0, 3));
      wr_e = AW'($urandom_range(0, 3)); wr_m = AW'($urandom_range(0, 3));
      wr_w = AW'($urandom_range(0, 3));
      {rw_e, rw_m, rw_w} = 3'($urandom);
      m2r_e = ($urandom_range(0, 3) == 0); m2r_m = ($urandom_range(0, 3) == 0);
      br_d = ($urandom_range(0, 3) == 0);
      md_start_d = ($urandom_range(0, 2) == 0); md_op_d = ($urandom_range(0, 3) == 0);
      hilo_d = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 63) != 0);
      #1;
      n_cmp++; if (fwd_ae !== exp_fwd_e(rs_e) || fwd_be !== exp_fwd_e(rt_e)) begin
        n_err++; $display("FAIL mix_fwd_e: got %b %b want %b %b", fwd_ae, fwd_be, exp_fwd_e(rs_e), exp_fwd_e(rt_e));
      end
      n_cmp++; if (fwd_ad !== exp_fwd_d(rs_d) || fwd_bd !== exp_fwd_d(rt_d)) begin
        n_err++; $display("FAIL mix_fwd_d: got %b %b want %b %b", fwd_ad, fwd_bd, exp_fwd_d(rs_d), exp_fwd_d(rt_d));
      end
      n_cmp++; if ({stall_f, stall_d, flush_e} !== {3{exp_stall()}}) begin
        n_err++; $display("FAIL mix_stall: got %b%b%b want %b", stall_f, stall_d, flush_e, exp_stall());
      end
      n_cmp++; if (md_busy !== (m_busy_left > 0)) begin
        n_err++; $display("FAIL mix_busy: got %b want %b", md_busy, (m_busy_left > 0));
      end
      n_cmp++; if (md_done !== m_done) begin n_err++; $display("FAIL mix_done: got %b want %b", md_done, m_done); end
      n_cmp++; if (md_start_e !== m_start) begin n_err++; $display("FAIL mix_starte: got %b want %b", md_start_e, m_start); end
      tick();
    end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_forward_directed();
    test_forward_random();
    test_load_use();
    test_branch();
    test_md_latency(1'b0);
    test_md_latency(1'b1);
    test_div_hilo();
    test_reset_abort();
    test_random_md();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL provide parameters: RF_ADDR_WIDTH, default 5, register-file address width; MUL_CYCLES, default 4, multiply latency in cycles; DIV_CYCLES, default 32, divide latency in cycles.
REQ-002 SHALL have ports: i_CLK  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have ports: i_RST_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: i_RsD, i_RtD  in  RF_ADDR_WIDTH each  decode-stage source registers.
REQ-005 SHALL have ports: i_RsE, i_RtE  in  RF_ADDR_WIDTH each  execute-stage source registers.
REQ-006 SHALL have ports: i_WriteRegE, i_WriteRegM, i_WriteRegW  in  RF_ADDR_WIDTH each  destination register per stage.
REQ-007 SHALL have ports: i_RegWriteE, i_RegWriteM, i_RegWriteW  in  1 each  destination valid per stage.
REQ-008 SHALL have ports: i_MemtoRegE, i_MemtoRegM  in  1 each  load in E / M.
REQ-009 SHALL have ports: i_BranchD  in  1  branch resolved in decode.
REQ-010 SHALL have ports: i_MDStartD  in  1  decode holds a multiply/divide; i_MDOpD  in  1  0 = multiply, 1 = divide; i_HiLoReadD  in  1  decode reads HI/LO.
REQ-011 SHALL have ports: o_ForwardAE, o_ForwardBE  out  2 each  EX operand select, 00 = register file, 01 = ResultW, 10 = ALUOutM; 11 never driven.
REQ-012 SHALL have ports: o_ForwardAD, o_ForwardBD  out  1 each  decode comparator takes ALUOutM.
REQ-013 SHALL have ports: o_StallF, o_StallD, o_FlushE  out  1 each  pipeline control.
REQ-014 SHALL have ports: o_MDStartE  out  1  one-cycle start to the multiply/divide unit; o_MDBusy  out  1  unit occupied; o_MDDone  out  1  one-cycle completion pulse.

Function
REQ-015 ForwardAE SHALL be 10 when RegWriteM, WriteRegM != 0 and WriteRegM == RsE; else 01 when RegWriteW, WriteRegW != 0 and WriteRegW == RsE; else 00; M has priority over W. ForwardBE identical using RtE.
REQ-016 Register 0 SHALL never be forwarded, on any path.
REQ-017 ForwardAD SHALL be 1 when RsD != 0, RsD == WriteRegM and RegWriteM; ForwardBD the same using RtD.
REQ-018 Load-use stall SHALL assert when MemtoRegE and (RtE == RsD or RtE == RtD), with the matched register nonzero.
REQ-019 Branch stall SHALL assert when BranchD and either: RegWriteE with WriteRegE nonzero and equal to RsD or RtD; or MemtoRegM with WriteRegM nonzero and equal to RsD or RtD.
REQ-020 MD stall SHALL assert when o_MDBusy and (i_MDStartD or i_HiLoReadD).
REQ-021 o_StallF = o_StallD = o_FlushE SHALL equal the OR of load-use, branch and MD stalls; all three are combinational, same cycle.
REQ-022 The MD FSM SHALL have states IDLE, BUSY and DONE; reset enters IDLE.
REQ-023 IDLE -> BUSY SHALL occur on an edge where i_MDStartD = 1 and no stall asserts. o_MDStartE SHALL be 1 for exactly the following cycle. The latency counter SHALL load MUL_CYCLES-1 when i_MDOpD = 0, else DIV_CYCLES-1.
REQ-024 In BUSY the counter SHALL decrement once per cycle; BUSY -> DONE SHALL occur on the edge where the counter equals 0.
REQ-025 o_MDBusy SHALL be 1 in BUSY only. A multiply SHALL occupy exactly MUL_CYCLES cycles of BUSY and a divide DIV_CYCLES cycles.
REQ-026 DONE SHALL last one cycle with o_MDDone = 1, then return to IDLE.
REQ-027 An i_MDStartD in DONE SHALL be accepted as in IDLE: DONE -> BUSY, with no idle cycle in between.
REQ-028 An i_MDStartD while BUSY SHALL be held by the stall and accepted only after the state leaves BUSY. A stalled start SHALL never be lost or accepted twice.
REQ-029 The counter SHALL be wide enough for DIV_CYCLES-1, SHALL never wrap below 0, and SHALL hold its value outside BUSY.

Reset
REQ-030 i_RST_n = 0 at an edge SHALL force: state IDLE, counter 0, o_MDStartE = 0, o_MDBusy = 0, o_MDDone = 0.
REQ-031 Reset SHALL abort an operation in progress, and no o_MDDone SHALL follow it.
REQ-032 Combinational outputs SHALL follow their inputs during reset, with the MD stall term forced to 0.

Verification
REQ-033 RegWriteM = 1, WriteRegM = 8, RegWriteW = 1, WriteRegW = 8, RsE = 8 -> ForwardAE = 10. Then RegWriteM = 0 -> ForwardAE = 01. Then WriteRegM = WriteRegW = 0 with RsE = 0 -> ForwardAE = 00.
REQ-034 MemtoRegE = 1, RtE = 5, RsD = 5 -> StallF = StallD = FlushE = 1 the same cycle. Then RtE = 0 with RsD = 0 -> all three = 0.
REQ-035 Multiply start (MDOpD = 0) -> o_MDStartE pulses one cycle, o_MDBusy = 1 for exactly 4 cycles, o_MDDone pulses in the 5th cycle. A divide gives o_MDBusy for exactly 32 cycles.
REQ-036 Divide in BUSY while HiLoReadD = 1 -> stalls asserted for every BUSY cycle and deasserted in DONE. A second start held during BUSY -> accepted at DONE, BUSY re-entered on the next cycle.
REQ-037 i_RST_n = 0 at BUSY cycle 10 of a divide -> next cycle IDLE, o_MDBusy = 0, no o_MDDone thereafter.
REQ-038 BranchD = 1, RegWriteE = 1, WriteRegE = RtD = 3 -> stall asserted. Next cycle, same register in M with MemtoRegM = 0 -> no stall, ForwardBD = 1.
